// File: rtl/bit_serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The controller uses the master side; the adder uses the slave side.
interface bit_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, input busy, done, sum, cout);
  modport slave  (input start, a, b, output busy, done, sum, cout);
endinterface

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder: one full-adder cell and a carry flop, one bit per clock.
// The result registers hold their value until the next operation completes.
//
// state  | meaning
// IDLE   | waiting for start; result registers hold the last sum
// RUN    | one operand bit pair added per cycle, LSB first
// DONE   | one-cycle done pulse; start here launches the next add
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  bit_serial_adder_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;

  logic             load;
  logic             last_bit;
  logic             ha0_s, ha0_c, ha1_c;
  logic             fa_s, fa_c;
  logic [WIDTH-1:0] acc_shift;

  // Full adder built from two half adders plus an OR for the carry.
  assign ha0_s     = sa_q[0] ^ sb_q[0];
  assign ha0_c     = sa_q[0] & sb_q[0];
  assign fa_s      = ha0_s ^ c_q;
  assign ha1_c     = ha0_s & c_q;
  assign fa_c      = ha0_c | ha1_c;
  assign acc_shift = {fa_s, acc_q[WIDTH-1:1]};

  assign load     = bus.start && (state_q != S_RUN);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (load) state_d = S_RUN;
      S_RUN:   if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = load ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == S_RUN);
    bus.done = (state_q == S_DONE);
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

  always_comb begin
    sa_d   = sa_q;
    sb_d   = sb_q;
    acc_d  = acc_q;
    c_d    = c_q;
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    if (load) begin
      sa_d  = bus.a;
      sb_d  = bus.b;
      acc_d = '0;
      c_d   = 1'b0;
      cnt_d = '0;
    end else if (state_q == S_RUN) begin
      sa_d  = {1'b0, sa_q[WIDTH-1:1]};
      sb_d  = {1'b0, sb_q[WIDTH-1:1]};
      acc_d = acc_shift;
      c_d   = fa_c;
      if (last_bit) begin
        sum_d  = acc_shift;
        cout_d = fa_c;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q   <= '0;
      sb_q   <= '0;
      acc_q  <= '0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sa_q   <= sa_d;
      sb_q   <= sb_d;
      acc_q  <= acc_d;
      c_q    <= c_d;
      cnt_q  <= cnt_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end
endmodule

// File: tb/tb_bit_serial_adder.sv
// Bench for bit_serial_adder: directed scenarios plus random starts, every cycle
// compared against an arithmetic model of the add latency and result.
module tb_bit_serial_adder;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bit_serial_adder_if #(.WIDTH(W)) bus ();

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_total = 0;
  int         n_bad   = 0;
  int         m_rem   = 0;
  bit         m_done  = 1'b0;
  logic [W-1:0] m_sum = '0;
  bit         m_cout  = 1'b0;
  logic [W:0] m_pend  = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".busy"}, 32'(bus.busy), 32'(m_rem > 0));
    chk({tag, ".done"}, 32'(bus.done), 32'(m_done));
    chk({tag, ".sum"},  32'(bus.sum),  32'(m_sum));
    chk({tag, ".cout"}, 32'(bus.cout), 32'(m_cout));
  endtask

  task automatic model_reset();
    m_rem  = 0;
    m_done = 1'b0;
    m_sum  = '0;
    m_cout = 1'b0;
  endtask

  // Model: an accepted add finishes W edges later, with result a+b.
  task automatic tick();
    if (rst_n) begin
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_done = 1'b1;
          {m_cout, m_sum} = m_pend;
        end
      end else if (bus.start) begin
        m_pend = {1'b0, bus.a} + {1'b0, bus.b};
        m_rem  = W;
        m_done = 1'b0;
      end else begin
        m_done = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_outs("cyc");
  endtask

  task automatic wait_done(output int ncyc);
    bit seen = 1'b0;
    ncyc = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      ncyc++;
      if (bus.done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_add(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] es, input bit ec);
    int n;
    bus.a = av;
    bus.b = bv;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(n);
    chk({tag, ".lat"},  32'(n), 32'(W));
    chk({tag, ".sum"},  32'(bus.sum), 32'(es));
    chk({tag, ".cout"}, 32'(bus.cout), 32'(ec));
    tick();
    tick();
    chk({tag, ".hold_sum"},  32'(bus.sum), 32'(es));
    chk({tag, ".hold_cout"}, 32'(bus.cout), 32'(ec));
  endtask

  initial begin
    int n;
    int dones;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    model_reset();

    // reset then idle
    #1;
    check_outs("rst");
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    run_add("ripple", 8'hFF, 8'h01, 8'h00, 1'b1);
    run_add("nocarry", 8'hA5, 8'h5A, 8'hFF, 1'b0);
    run_add("msb", 8'h80, 8'h80, 8'h00, 1'b1);

    // start while busy is ignored
    bus.a = 8'h03;
    bus.b = 8'h04;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(n);
    chk("ign.sum",  32'(bus.sum), 32'h07);
    chk("ign.cout", 32'(bus.cout), 32'd0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) dones++;
    end
    chk("ign.extra_done", 32'(dones), 32'd0);

    // back-to-back with start held
    bus.a = 8'h10;
    bus.b = 8'h20;
    bus.start = 1'b1;
    wait_done(n);
    chk("b2b1.sum",  32'(bus.sum), 32'h30);
    chk("b2b1.cout", 32'(bus.cout), 32'd0);
    bus.a = 8'hF0;
    bus.b = 8'h20;
    wait_done(n);
    chk("b2b2.gap",  32'(n), 32'(W + 1));
    chk("b2b2.sum",  32'(bus.sum), 32'h10);
    chk("b2b2.cout", 32'(bus.cout), 32'd1);
    bus.start = 1'b0;
    tick();
    tick();

    // reset mid-run aborts without done
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outs("midrst");
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.done) dones++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.done) dones++;
    end
    chk("midrst.no_done", 32'(dones), 32'd0);
    run_add("after_rst", 8'h01, 8'h01, 8'h02, 1'b0);

    // random starts and operands
    for (int i = 0; i < 400; i++) begin
      bus.start = ($urandom_range(0, 2) == 0);
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      tick();
    end
    bus.start = 1'b0;
    for (int i = 0; i < W + 2; i++) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/bit_serial_adder.md
# bit_serial_adder

Bit-serial ripple adder that adds two WIDTH-bit operands LSB-first, one bit per clock, using a single full-adder cell (two `ha_data` half adders plus an OR for carry) and a carry flip-flop. It sits directly downstream of the half-adder cell and is the first sequential datapath built on it. A start/busy/done handshake exposes it to a controller or testbench, and the result is held until the next operation.

## Interface
- `WIDTH`, default 8: operand and sum width, ≥ 2.

- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request an add; sampled on `clk` rise.
- `a` in WIDTH: operand A; captured only when `start` is accepted.
- `b` in WIDTH: operand B; captured only when `start` is accepted.
- `busy` out 1: high while an add is in progress (LOAD accepted → last bit).
- `done` out 1: one-cycle pulse; `sum` and `cout` are valid from this cycle.
- `sum` out WIDTH: registered result (a + b) mod 2^WIDTH.
- `cout` out 1: registered carry-out of bit WIDTH-1.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `start`=1 captures `a` and `b` into shift registers `sa` and `sb`, clears the carry flip-flop `c` and the bit counter `cnt`, and moves to RUN.
- RUN, each cycle:
  - full-adder bit s = `sa[0]`^`sb[0]`^`c`; c_next = majority(`sa[0]`, `sb[0]`, `c`).
  - s shifts into the MSB of internal register `acc` (right-shift).
  - `sa` and `sb` shift right; `c` ← c_next; `cnt`++.
  - When `cnt` = WIDTH-1 on that edge (the last bit), go to DONE. In the same edge, `sum` ← final `acc` value and `cout` ← c_next.
- DONE: `done`=1 for exactly one cycle.
  - `start`=1 in DONE: accepted exactly as in IDLE (load, go to RUN). This allows back-to-back operation.
  - Otherwise go to IDLE.
- `start` while in RUN is ignored; operands are not re-captured.
- `sum` and `cout` change only on the DONE-entry edge and otherwise hold their value, including through IDLE and RUN of the next operation.
- `busy` = (state == RUN); `done` = (state == DONE). Both are decoded from registered state, with no combinational path from `start`.
- `cnt` width is clog2(WIDTH), with a minimum of 1 bit. It never wraps within an operation.

## Timing
- Reset (`rst_n`=0, asynchronous): state=IDLE, `busy`=0, `done`=0, `sum`=0, `cout`=0, and `sa`, `sb`, `acc`, `c`, `cnt` all 0.
- Reset asserted mid-RUN aborts immediately. The partial result is discarded, `sum` returns to 0, and no `done` pulse follows.
- Release of reset is synchronous to `clk` in effect: the first `start` is honoured on the first rising edge with `rst_n`=1.
- Latency (start accepted on edge 0):
  - `busy`=1 after edges 0 … WIDTH-1.
  - Bit i is computed on edge i+1 for i = 0 … WIDTH-1.
  - `done`=1 and `sum`/`cout` are valid after edge WIDTH.
  - `busy`=0 in the DONE cycle.
- Throughput: one add per WIDTH+1 cycles when `start` is held or re-asserted in DONE.

## Test plan
- Reset then idle: hold `rst_n`=0 for 2 cycles, then release with `start`=0 for 5 cycles → `busy`=0, `done`=0, `sum`=0, `cout`=0 throughout.
- Carry ripple, WIDTH=8: `a`=8'hFF, `b`=8'h01, one-cycle `start` → `busy` high for 8 cycles, `done` pulse on cycle 9, `sum`=8'h00, `cout`=1. Values hold after `done` falls.
- No carry: `a`=8'hA5, `b`=8'h5A → `sum`=8'hFF, `cout`=0. Also `a`=8'h80, `b`=8'h80 → `sum`=8'h00, `cout`=1.
- Start ignored while busy: begin 8'h03 + 8'h04; on cycle 3 pulse `start` with `a`=8'hFF, `b`=8'hFF → single `done` with `sum`=8'h07, `cout`=0, and no second operation.
- Back-to-back: hold `start`=1 with `a`=8'h10, `b`=8'h20, then change operands to 8'hF0, 8'h20 in the first DONE cycle → first `done` gives 8'h30/0, second `done` exactly 9 cycles later gives 8'h10/1.
- Reset mid-run: deassert `rst_n` during cycle 4 of 8'hFF + 8'hFF → outputs 0 immediately, no `done` pulse, and the next add 8'h01 + 8'h01 gives 8'h02/0.
